id_ex_stage: RTL and testbench

ID/EX pipeline register of the five-stage RV32I core. It captures decoded operands, register indices and control from ID and presents them to EX, including the `EX_rs1`/`EX_rs2` indices consumed by the forwarding unit. It also contains the load-use hazard detector, which inserts a bubble whenever EX holds a load whose destination ID needs. The global memory-wait stall and branch flush are applied here with a defined priority.

---
 rtl/id_ex_stage_if.sv | 56 +++++
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side operands/control in, EX-side registered copies out.
`default_nettype none

interface id_ex_stage_if #(
  parameter int CTRL_W = 12
);
  logic              stall_mem;
  logic              flush;
  logic              ID_valid;
  logic [31:0]       ID_pc;
  logic [4:0]        ID_rs1;
  logic [4:0]        ID_rs2;
  logic [4:0]        ID_rd;
  logic              ID_use_rs1;
  logic              ID_use_rs2;
  logic [31:0]       ID_rs1_data;
  logic [31:0]       ID_rs2_data;
  logic [31:0]       ID_imm;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_MemWrite;
  logic [CTRL_W-1:0] ID_ctrl;
  logic              load_use_stall;
  logic              EX_valid;
  logic [31:0]       EX_pc;
  logic [4:0]        EX_rs1;
  logic [4:0]        EX_rs2;
  logic [4:0]        EX_rd;
  logic [31:0]       EX_rs1_data;
  logic [31:0]       EX_rs2_data;
  logic [31:0]       EX_imm;
  logic              EX_RegWrite;
  logic              EX_MemRead;
  logic              EX_MemWrite;
  logic [CTRL_W-1:0] EX_ctrl;

  modport master (
    output stall_mem, flush, ID_valid, ID_pc, ID_rs1, ID_rs2, ID_rd,
           ID_use_rs1, ID_use_rs2, ID_rs1_data, ID_rs2_data, ID_imm,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ctrl,
    input  load_use_stall, EX_valid, EX_pc, EX_rs1, EX_rs2, EX_rd,
           EX_rs1_data, EX_rs2_data, EX_imm, EX_RegWrite, EX_MemRead,
           EX_MemWrite, EX_ctrl
  );

  modport slave (
    input  stall_mem, flush, ID_valid, ID_pc, ID_rs1, ID_rs2, ID_rd,
           ID_use_rs1, ID_use_rs2, ID_rs1_data, ID_rs2_data, ID_imm,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ctrl,
    output load_use_stall, EX_valid, EX_pc, EX_rs1, EX_rs2, EX_rd,
           EX_rs1_data, EX_rs2_data, EX_imm, EX_RegWrite, EX_MemRead,
           EX_MemWrite, EX_ctrl
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ==========================================================================
// id_ex_stage : ID/EX pipeline register with load-use hazard detection,
//               memory-stall hold and branch-flush bubble insertion.
//               Optional bubble counter enabled by ID_EX_PERF_EN.
// Revision    : 1.0
// ==========================================================================
`default_nettype none

module id_ex_stage #(
  parameter int CTRL_W = 12
) (
  input  wire logic        clk,
  input  wire logic        rst,
  id_ex_stage_if.slave     bus,
  output logic [15:0]      bubble_cnt
);

  logic flush_pend;
  logic hz;
  logic flush_eff;
  logic load_bubble;

  always_comb begin
    hz = bus.EX_valid & bus.EX_MemRead & bus.EX_RegWrite & (bus.EX_rd != 5'd0) &
         bus.ID_valid &
         ((bus.ID_use_rs1 & (bus.ID_rs1 == bus.EX_rd)) |
          (bus.ID_use_rs2 & (bus.ID_rs2 == bus.EX_rd)));
    flush_eff   = bus.flush | flush_pend;
    load_bubble = flush_eff | hz;
  end

  assign bus.load_use_stall = hz & ~flush_eff;

  // A flush seen while stalled must survive until the first free edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend <= 1'b0;
    end else if (bus.stall_mem) begin
      if (bus.flush) flush_pend <= 1'b1;
    end else begin
      flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.EX_valid    <= 1'b0;
      bus.EX_pc       <= 32'h0;
      bus.EX_rs1      <= 5'd0;
      bus.EX_rs2      <= 5'd0;
      bus.EX_rd       <= 5'd0;
      bus.EX_rs1_data <= 32'h0;
      bus.EX_rs2_data <= 32'h0;
      bus.EX_imm      <= 32'h0;
      bus.EX_RegWrite <= 1'b0;
      bus.EX_MemRead  <= 1'b0;
      bus.EX_MemWrite <= 1'b0;
      bus.EX_ctrl     <= '0;
    end else if (!bus.stall_mem) begin
      if (load_bubble) begin
        // Zero indices keep the forwarding unit from matching a bubble.
        bus.EX_valid    <= 1'b0;
        bus.EX_pc       <= 32'h0;
        bus.EX_rs1      <= 5'd0;
        bus.EX_rs2      <= 5'd0;
        bus.EX_rd       <= 5'd0;
        bus.EX_rs1_data <= 32'h0;
        bus.EX_rs2_data <= 32'h0;
        bus.EX_imm      <= 32'h0;
        bus.EX_RegWrite <= 1'b0;
        bus.EX_MemRead  <= 1'b0;
        bus.EX_MemWrite <= 1'b0;
        bus.EX_ctrl     <= '0;
      end else begin
        bus.EX_valid    <= bus.ID_valid;
        bus.EX_pc       <= bus.ID_pc;
        bus.EX_rs1      <= bus.ID_rs1;
        bus.EX_rs2      <= bus.ID_rs2;
        bus.EX_rd       <= bus.ID_rd;
        bus.EX_rs1_data <= bus.ID_rs1_data;
        bus.EX_rs2_data <= bus.ID_rs2_data;
        bus.EX_imm      <= bus.ID_imm;
        bus.EX_RegWrite <= bus.ID_valid & bus.ID_RegWrite;
        bus.EX_MemRead  <= bus.ID_valid & bus.ID_MemRead;
        bus.EX_MemWrite <= bus.ID_valid & bus.ID_MemWrite;
        bus.EX_ctrl     <= bus.ID_valid ? bus.ID_ctrl : '0;
      end
    end
  end

`ifdef ID_EX_PERF_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'h0000;
    end else if (!bus.stall_mem && load_bubble && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign bubble_cnt = cnt;
`else
  assign bubble_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID vectors, expected EX snapshots queued per edge.
`default_nettype none

module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [11:0] ctrl;
    logic [15:0] cnt;
  } ex_t;

  logic        clk;
  logic        rst;
  logic [15:0] bubble_cnt;

  id_ex_stage_if #(.CTRL_W(12)) bus ();

  id_ex_stage #(.CTRL_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  ex_t   sb_q[$];
  string nm_q[$];
  ex_t   last;
  logic [15:0] exp_cnt = 16'h0;

  function automatic ex_t dut_snap();
    ex_t s;
    s.v = bus.EX_valid; s.pc = bus.EX_pc; s.rs1 = bus.EX_rs1; s.rs2 = bus.EX_rs2;
    s.rd = bus.EX_rd; s.d1 = bus.EX_rs1_data; s.d2 = bus.EX_rs2_data; s.imm = bus.EX_imm;
    s.rw = bus.EX_RegWrite; s.mr = bus.EX_MemRead; s.mw = bus.EX_MemWrite;
    s.ctrl = bus.EX_ctrl; s.cnt = bubble_cnt;
    return s;
  endfunction

  // Monitor: one queued expectation is consumed per clock, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      ex_t e, a;
      string n;
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      a = dut_snap();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: actual v=%b pc=%h rs1=%0d rd=%0d rw=%b mr=%b cnt=%h (%h) required v=%b pc=%h rs1=%0d rd=%0d rw=%b mr=%b cnt=%h (%h)",
                 n, a.v, a.pc, a.rs1, a.rd, a.rw, a.mr, a.cnt, a,
                 e.v, e.pc, e.rs1, e.rd, e.rw, e.mr, e.cnt, e);
      end
    end
  end

  task automatic chk_bit(input string n, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", n, act, req);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic rw, input logic mr, input logic mw);
    bus.ID_valid = v; bus.ID_pc = pc; bus.ID_rs1 = rs1; bus.ID_rs2 = rs2; bus.ID_rd = rd;
    bus.ID_use_rs1 = u1; bus.ID_use_rs2 = u2;
    bus.ID_rs1_data = pc ^ 32'hA5A5_0000;
    bus.ID_rs2_data = pc + 32'h0000_1111;
    bus.ID_imm = ~pc;
    bus.ID_RegWrite = rw; bus.ID_MemRead = mr; bus.ID_MemWrite = mw;
    bus.ID_ctrl = pc[11:0] ^ 12'h5A5;
    #1;
  endtask

  // Expected EX contents after a normal load of the currently driven ID vector.
  function automatic ex_t exp_id();
    ex_t e;
    e.v = bus.ID_valid; e.pc = bus.ID_pc; e.rs1 = bus.ID_rs1; e.rs2 = bus.ID_rs2;
    e.rd = bus.ID_rd; e.d1 = bus.ID_rs1_data; e.d2 = bus.ID_rs2_data; e.imm = bus.ID_imm;
    e.rw = bus.ID_valid & bus.ID_RegWrite;
    e.mr = bus.ID_valid & bus.ID_MemRead;
    e.mw = bus.ID_valid & bus.ID_MemWrite;
    e.ctrl = bus.ID_valid ? bus.ID_ctrl : 12'h0;
    e.cnt = exp_cnt;
    return e;
  endfunction

  function automatic ex_t bub();
    ex_t e;
    e = '0;
    e.cnt = exp_cnt;
    return e;
  endfunction

  task automatic note_bubble();
`ifdef ID_EX_PERF_EN
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  task automatic cyc(input ex_t e, input string n);
    sb_q.push_back(e);
    nm_q.push_back(n);
    last = e;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input string n);
    ex_t h;
    h = last;
    h.cnt = exp_cnt;
    cyc(h, n);
  endtask

  initial begin
    rst = 1'b0;
    bus.stall_mem = 1'b0;
    bus.flush = 1'b0;
    set_id($urandom_range(0, 1), $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
           1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk); #1;

    // Reset holds everything at zero regardless of ID inputs
    cyc(bub(), "reset_zero0");
    set_id(1'b1, $urandom, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(bub(), "reset_zero1");
    rst = 1'b1;
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(exp_id(), "first_load");

    // Load-use: lw x5 then add x6,x5,x1
    set_id(1'b1, 32'h104, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_bit("lus_before_load", bus.load_use_stall, 1'b0);
    cyc(exp_id(), "lw_x5");
    set_id(1'b1, 32'h108, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_bit("lus_asserted", bus.load_use_stall, 1'b1);
    note_bubble();
    cyc(bub(), "lu_bubble");
    chk_bit("lus_released", bus.load_use_stall, 1'b0);
    cyc(exp_id(), "lu_dependent");

    // rd=x0 load and unused-operand match never stall
    set_id(1'b1, 32'h10C, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(exp_id(), "lw_x0");
    set_id(1'b1, 32'h110, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_bit("lus_x0", bus.load_use_stall, 1'b0);
    cyc(exp_id(), "use_x0");
    set_id(1'b1, 32'h114, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(exp_id(), "lw_x7");
    set_id(1'b1, 32'h118, 5'd3, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_bit("lus_unused_rs2", bus.load_use_stall, 1'b0);
    cyc(exp_id(), "unused_rs2");

    // Invalid ID on a normal load drops its control
    set_id(1'b0, 32'h11C, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(exp_id(), "invalid_ctrl_zero");

    // Memory stall together with a load-use hazard
    set_id(1'b1, 32'h120, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(exp_id(), "lw_x9");
    bus.stall_mem = 1'b1;
    set_id(1'b1, 32'h124, 5'd9, 5'd2, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_bit("lus_in_stall0", bus.load_use_stall, 1'b1);
    hold("stall_hz_hold0");
    set_id(1'b1, 32'h128, 5'd4, 5'd9, 5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_bit("lus_in_stall1", bus.load_use_stall, 1'b1);
    hold("stall_hz_hold1");
    bus.stall_mem = 1'b0;
    #1;
    chk_bit("lus_at_release", bus.load_use_stall, 1'b1);
    note_bubble();
    cyc(bub(), "stall_hz_bubble");
    chk_bit("lus_after_bubble", bus.load_use_stall, 1'b0);
    cyc(exp_id(), "after_stall_hz");

    // Memory stall with ID changing every cycle
    bus.stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h200 + 32'(i * 4), 5'(i + 1), 5'(i + 2), 5'(i + 12),
             1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      hold("mem_stall_hold");
    end
    bus.stall_mem = 1'b0;
    set_id(1'b1, 32'h300, 5'd3, 5'd4, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(exp_id(), "stall_release_capture");

    // Flush beats a simultaneous load-use hazard
    set_id(1'b1, 32'h304, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(exp_id(), "lw_x10");
    set_id(1'b1, 32'h308, 5'd10, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    chk_bit("lus_flush_wins", bus.load_use_stall, 1'b0);
    note_bubble();
    cyc(bub(), "flush_beats_hz");
    bus.flush = 1'b0;

    // Flush pulse during a stall is remembered
    set_id(1'b1, 32'h30C, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(exp_id(), "pre_flush_stall");
    bus.stall_mem = 1'b1;
    bus.flush = 1'b1;
    set_id(1'b1, 32'h310, 5'd1, 5'd2, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    hold("flush_stall_hold0");
    bus.flush = 1'b0;
    hold("flush_stall_hold1");
    hold("flush_stall_hold2");
    bus.stall_mem = 1'b0;
    set_id(1'b1, 32'h314, 5'd1, 5'd2, 5'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    note_bubble();
    cyc(bub(), "pend_bubble");
    set_id(1'b1, 32'h318, 5'd1, 5'd2, 5'd17, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(exp_id(), "after_pend");

    // Reset during a stall with a pending flush clears the pending flush
    set_id(1'b1, 32'h31C, 5'd1, 5'd2, 5'd18, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(exp_id(), "pre_reset_stall");
    bus.stall_mem = 1'b1;
    bus.flush = 1'b1;
    hold("stall_flush_before_reset");
    bus.flush = 1'b0;
    rst = 1'b0;
    #1;
    chk_bit("async_reset_valid", bus.EX_valid, 1'b0);
    checks++;
    if (bus.EX_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_pc: actual=%h required=%h", bus.EX_pc, 32'h0);
    end
    exp_cnt = 16'h0;
    cyc(bub(), "reset_in_stall");
    rst = 1'b1;
    bus.stall_mem = 1'b0;
    set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd19, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(exp_id(), "post_reset_load");

    // Long flush run: counter saturates rather than wrapping
    set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    for (int i = 0; i < 70000; i++) note_bubble();
    repeat (70000) @(posedge clk);
    @(negedge clk); #1;
    note_bubble();
    cyc(bub(), "cnt_saturated");
    bus.flush = 1'b0;
    set_id(1'b1, 32'h504, 5'd1, 5'd2, 5'd21, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(exp_id(), "cnt_after_flush");

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
